// File: rtl/scale_mux_pkg.sv
// Shared defaults and mode names for the arbitrating scale mux.
// No ports: constants and the mux_mode_e enum only.
package scale_mux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter owning the rr pointer.
// Ports: clk, rst_n, req, rr_en, advance in; one-hot grant, idx out.
module rr_arbiter
  import scale_mux_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           rr_en,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] idx
);

  if (NCH == 1) begin : g_single
    logic unused_in;
    assign unused_in = ^{clk, rst_n, rr_en, advance};
    assign grant = req;
    assign idx   = '0;
  end else begin : g_multi
    logic [CHW-1:0] ptr;
    logic [CHW-1:0] c;
    logic           found;

    // In fixed mode the scan starts at 0,
    // so the lowest valid index wins.
    always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = '0;
      for (int i = 0; i < NCH; i++) begin
        if (rr_en)
          c = CHW'((int'(ptr) + i) % NCH);
        else
          c = CHW'(i);
        if (!found && req[c]) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          idx      = c;
        end
      end
    end

    // Pointer is frozen in fixed mode and
    // resumes from its value when rr returns.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ptr <= '0;
      else if (advance && rr_en)
        ptr <= (idx == CHW'(NCH - 1)) ?
               '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/scale_mux_arb.sv
// N-channel arbitrating mux with a registered, backpressured output.
// Ports: i_clk, i_rst_n, i_rr_en, i_in_data/valid, o_in_ready,
//        o_out_data/ch/valid, i_out_ready.
module scale_mux_arb
  import scale_mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rr_en,
  input  logic [WIDTH-1:0] i_in_data [NCH],
  input  logic [NCH-1:0]   i_in_valid,
  output logic [NCH-1:0]   o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CHW-1:0]   o_out_ch,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic           load;
  logic           in_xfer;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] idx;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req     (i_in_valid),
    .rr_en   (i_rr_en),
    .advance (in_xfer),
    .grant   (grant),
    .idx     (idx)
  );

  // The register can take a beat when empty
  // or when its current beat leaves this cycle.
  assign load = !o_out_valid || i_out_ready;

  // Reset also blocks ready, so nothing is
  // accepted while the block is held in reset.
  assign o_in_ready = (load && i_rst_n) ?
                      grant : '0;

  assign in_xfer = |(o_in_ready & i_in_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_ch    <= '0;
    end else if (in_xfer) begin
      o_out_valid <= 1'b1;
      o_out_data  <= i_in_data[idx];
      o_out_ch    <= idx;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/scale_mux_arb.md
# scale_mux_arb

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output and a valid/ready handshake on every port. It is the next generation of the 2:1 combinational scale mux. Instead of an external select, an internal arbiter picks one requesting channel per cycle, using either round-robin or fixed-priority order. The result is held in an output register that absorbs backpressure. It sits between several producer streams and one shared consumer.

## Interface
- `WIDTH`, 8, data width per channel in bits
- `NCH`, 4, number of input channels (≥1)
- `CHW`, `(NCH>1) ? $clog2(NCH) : 1`, width of channel index (derived, not overridden)

- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_rr_en`  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
- `i_in_data`  in  NCH×WIDTH  per-channel data, unpacked array `[NCH]`
- `i_in_valid`  in  NCH  per-channel request
- `o_in_ready`  out  NCH  per-channel accept, one-hot or zero
- `o_out_data`  out  WIDTH  registered selected data
- `o_out_ch`  out  CHW  index of the channel that produced `o_out_data`
- `o_out_valid`  out  1  output register holds a beat
- `i_out_ready`  in  1  consumer accepts the beat

## Operation
- Transfer on input k: `i_in_valid[k] && o_in_ready[k]` at a rising edge. Transfer on output: `o_out_valid && i_out_ready`.
- `load = !o_out_valid || i_out_ready`. When `load` is 0, all `o_in_ready` bits are 0.
- Arbitration is combinational over the current `i_in_valid` and `i_rr_en`. It produces a one-hot `grant`, and `o_in_ready = load ? grant : 0`.
- Fixed priority: the lowest-index valid channel wins. The pointer is not used and not updated.
- Round-robin: search starts at `ptr`, runs ascending, and wraps from NCH-1 to 0. The first valid channel wins. On each input transfer, `ptr <= (granted idx == NCH-1) ? 0 : idx+1`.
- On an input transfer:
  - `o_out_data <= i_in_data[idx]`, `o_out_ch <= idx`, `o_out_valid <= 1`.
- On an output transfer with no input transfer: `o_out_valid <= 0`. Data and channel index hold their last value.
- While `o_out_valid && !i_out_ready`: data, channel index and valid are held stable.
- Switching `i_rr_en`:
  - Takes effect in the same cycle's arbitration.
  - `ptr` keeps its value across mode changes and resumes from it.
- NCH=1: no arbitration. The block is a one-entry register slice with `o_out_ch` tied to 0.

## Timing
- Reset values (asynchronous, immediate on `i_rst_n` low): `o_out_valid=0`, `o_out_data=0`, `o_out_ch=0`, `ptr=0`. `o_in_ready` is 0 while in reset.
- Reset asserted mid-transfer discards the held beat. There is no partial state.
- Latency: an accepted input appears on the output 1 cycle after its transfer edge.
- Throughput: 1 beat/cycle when `i_out_ready` is held high.
- `o_in_ready` depends combinationally on `i_in_valid`, `i_rr_en` and `i_out_ready`. `o_out_*` are registered only.
- An input transfer and an output transfer in the same cycle give back-to-back beats with no bubble.

## Structure
- Package `scale_mux_pkg`: default `WIDTH`/`NCH` constants and a `mux_mode_e` enum (`MODE_FIXED`, `MODE_RR`) for bench readability. `i_rr_en` stays a 1-bit port.
- Sub-module `rr_arbiter`:
  - Parameter `NCH`.
  - Inputs: request vector, `rr_en`, `advance`, clock and reset.
  - Outputs: one-hot grant and granted index.
  - It owns `ptr`.
- The top level owns `load`, the output register and ready gating.

## Test plan
- Reset: drive a beat so `o_out_valid=1`, `o_out_data=0x11`, then pull `i_rst_n` low mid-cycle → `o_out_valid`, `o_out_data`, `o_out_ch` read 0 immediately, before the next edge.
- Round-robin sweep: NCH=4, data 0x10/0x11/0x12/0x13, all valid, `i_rr_en=1`, `i_out_ready=1` → `o_out_data` runs 10,11,12,13,10 on consecutive cycles and `o_out_ch` runs 0,1,2,3,0.
- Fixed priority: same stimulus with `i_rr_en=0` → `o_out_data=0x10` every cycle and `o_in_ready=4'b0001` throughout.
- Backpressure: with output holding 0x11, drop `i_out_ready` for 3 cycles → `o_out_data=0x11`, `o_out_valid=1` and `o_in_ready=0` for all 3 cycles. Re-raise it → 0x12 appears on the next edge with no bubble.
- Wrap and sparse requests: with `ptr=3` and only ch2 valid (data 0xA2) → grant ch2, output 0xA2, `ptr` becomes 3. Then only ch0 valid (0xB0) → grant ch0, output 0xB0, `ptr` becomes 1.
- NCH=1, WIDTH=16: valid stream 0x1234, 0xBEEF with one stall cycle → values emerge in order, 1-cycle latency, `o_out_ch=0`.
